ascii_to_bin_packer: RTL and testbench
======================================

Name: ascii_to_bin_packer

Overview:
- Inverse of the 112-bit-to-16-character splitter: accepts 7-bit ASCII characters one per handshake and packs 16 of them into one 112-bit binary word.
- The packed word feeds the Hamming encoder/data path.
- Double-buffered: an accumulation register fills while the previous completed word waits in an output register.
- A flush input closes a partial word, padding the unused slots with a pad character.

Parameters:
- CHAR_W, 7, bits per character.
- NUM_CHARS, 16, characters per word; word width = CHAR_W*NUM_CHARS (112).
- PAD_CHAR, 7'h20, fill value for unused slots on flush.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- char_in  in  CHAR_W  ASCII character.
- char_valid  in  1  char_in valid.
- char_ready  out  1  packer can accept char_in this cycle.
- flush  in  1  single-cycle request to close the current partial word.
- word_out  out  CHAR_W*NUM_CHARS  packed word; slot k = bits [7k+6:7k].
- word_valid  out  1  word_out holds a completed word.
- word_ready  in  1  downstream consumes word_out.
- char_count  out  5  characters in the accumulation register (0..NUM_CHARS-1).

Behaviour:
- Reset (async assert, sync-safe deassert) clears the following:
  - accumulation register = 0
  - char_count = 0
  - word_out = 0
  - word_valid = 0
  - char_ready = 1
- Char accept occurs when char_valid && char_ready. The character is written to slot char_count, and char_count increments. The first character accepted after a word boundary lands in bits [6:0].
- Completion: accepting the character when char_count == NUM_CHARS-1 completes the word.
  - On the next edge, word_out = accumulated word including that character, word_valid = 1, char_count = 0.
  - Latency: 1 clock from the last accept to word_valid.
- Output handshake: word_out and word_valid are held stable while word_valid && !word_ready. word_valid drops on the edge after word_valid && word_ready, unless a new word completes on that same edge; in that case word_out loads the new word and word_valid stays 1.
- Backpressure: char_ready = !(char_count == NUM_CHARS-1 && word_valid && !word_ready). Accumulation of characters 0..14 of the next word continues while the output is held.
- States:
  - EMPTY (count = 0, no output pending)
  - FILLING (count > 0)
  - HOLD (word_valid = 1; orthogonal to the fill count)
  - Implemented as char_count plus the word_valid flag; no separate encoded FSM is required.
- Flush when char_count > 0 and no char accept in the same cycle:
  - Slots char_count..NUM_CHARS-1 are filled with PAD_CHAR.
  - The word completes exactly as a normal completion; char_count becomes 0.
  - If the output is busy (word_valid && !word_ready), flush stays pending internally (one flag) until the output frees, then completes.
  - char_ready = 0 while a flush is pending.
- Flush together with a char accept: the character is written first, then the rest of the word is padded. If that character was slot 15, this is a normal completion with no padding.
- Flush with char_count == 0 and no accept is ignored; no empty word is emitted.
- Async reset mid-word discards the partial word and any pending output immediately.
- No arithmetic beyond the 5-bit count; the count never exceeds NUM_CHARS-1.

Decomposition:
- Shared package holds:
  - CHAR_W
  - NUM_CHARS
  - WORD_W = CHAR_W*NUM_CHARS
  - PAD_CHAR
  - a slot-index typedef (5 bits)
- The existing splitter should also use this package.
- One natural sub-module: ascii_slot_writer. It is combinational and returns the accumulation register with slot i replaced, plus the padding mask for flush.
- The rest is single-module RTL.

Test Plan:
- Stream "HELLO_HAMMING_16" (16 chars) with word_ready=1 -> 1 cycle after the 16th accept, word_valid=1 and word_out[6:0]=7'h48, word_out[111:105]=7'h36.
- Send 5 chars "ABCDE" then pulse flush -> word_out slots 0..4 = 41..45, slots 5..15 = 7'h20, char_count returns to 0.
- Hold word_ready=0 after word 1 and keep sending -> 15 more accepts, then char_ready=0 at count 15 and word_out unchanged. Raise word_ready -> accept resumes, second word appears on the cycle after word 1 is consumed, with no lost or duplicated chars.
- Flush with char_count=0 -> no word_valid. Flush on the same cycle as the 16th char -> a normal word with no pad.
- Assert rst_n=0 mid-word (count=9) with word_valid=1 -> all outputs are 0 immediately. After release, a fresh 16-char word packs from slot 0.
- Random valid/ready throttling over 1000 chars vs a reference queue model -> every word matches, and word_out stays stable while stalled.

Source files
------------

// File: rtl/ascii_to_bin_packer_pkg.sv
// Shared constants and types for the ASCII <-> 112-bit word data path.
// Used by the packer and by the companion 112-bit-to-16-character splitter.
package ascii_to_bin_packer_pkg;

    localparam int unsigned CHAR_W    = 7;
    localparam int unsigned NUM_CHARS = 16;
    localparam int unsigned WORD_W    = CHAR_W * NUM_CHARS;

    localparam logic [CHAR_W-1:0] PAD_CHAR = 7'h20;

    // Slot index / character count; one bit wider than needed so that
    // "one past the last slot" (16) is representable.
    typedef logic [4:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(NUM_CHARS - 1);

endpackage

// File: rtl/ascii_to_bin_packer_if.sv
// Character-in / word-out handshake bundle for ascii_to_bin_packer.
//   master : character producer and word consumer (drives char_*, flush, word_ready)
//   slave  : the packer (drives char_ready, word_out, word_valid, char_count)
interface ascii_to_bin_packer_if;
    import ascii_to_bin_packer_pkg::*;

    logic [CHAR_W-1:0] char_in;
    logic              char_valid;
    logic              char_ready;
    logic              flush;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    slot_t             char_count;

    modport master (
        output char_in, char_valid, flush, word_ready,
        input  char_ready, word_out, word_valid, char_count
    );

    modport slave (
        input  char_in, char_valid, flush, word_ready,
        output char_ready, word_out, word_valid, char_count
    );

endinterface

// File: rtl/ascii_to_bin_packer_slot_writer.sv
// ascii_slot_writer: combinational helper for the packer.
//   acc_i      : current accumulation word
//   slot_i     : slot to overwrite with char_i when we_i is set
//   pad_from_i : first slot to be padded on a flush (NUM_CHARS => no padding)
//   acc_o      : acc_i with the selected slot replaced
//   pad_mask_o : all-ones over every slot >= pad_from_i
module ascii_slot_writer
    import ascii_to_bin_packer_pkg::*;
(
    input  logic [WORD_W-1:0] acc_i,
    input  slot_t             slot_i,
    input  logic [CHAR_W-1:0] char_i,
    input  logic              we_i,
    input  slot_t             pad_from_i,
    output logic [WORD_W-1:0] acc_o,
    output logic [WORD_W-1:0] pad_mask_o
);

    always_comb begin
        acc_o      = acc_i;
        pad_mask_o = '0;
        for (int unsigned k = 0; k < NUM_CHARS; k++) begin
            if (we_i && (slot_i == slot_t'(k))) begin
                acc_o[k*CHAR_W +: CHAR_W] = char_i;
            end
            if (slot_t'(k) >= pad_from_i) begin
                pad_mask_o[k*CHAR_W +: CHAR_W] = {CHAR_W{1'b1}};
            end
        end
    end

endmodule

// File: rtl/ascii_to_bin_packer.sv
// ascii_to_bin_packer: packs 16 7-bit ASCII characters into one 112-bit word.
// An accumulation register fills while the previous word waits in the output
// register. A flush closes a partial word, padding unused slots with PAD_CHAR.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_io : slave side of the character/word handshake bundle
module ascii_to_bin_packer
    import ascii_to_bin_packer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    ascii_to_bin_packer_if.slave   bus_io
);

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] word_q, word_d;
    slot_t             count_q, count_d;
    logic              word_valid_q, word_valid_d;
    logic              flush_pend_q, flush_pend_d;

    logic              out_free;
    logic              char_ready;
    logic              accept;
    logic              flush_eff;
    logic              close;
    slot_t             pad_from;
    logic [WORD_W-1:0] acc_wr;
    logic [WORD_W-1:0] pad_mask;
    logic [WORD_W-1:0] packed_word;

    always_comb begin
        out_free   = !word_valid_q || bus_io.word_ready;
        // Slot 15 can only be taken if the completed word has somewhere to go.
        char_ready = !flush_pend_q && !((count_q == LAST_SLOT) && !out_free);
        accept     = bus_io.char_valid && char_ready;
        pad_from   = count_q + {4'b0, accept};
        // A flush on an empty accumulator with no accept is dropped.
        flush_eff  = flush_pend_q || (bus_io.flush && (accept || (count_q != '0)));
    end

    ascii_slot_writer u_slot_writer (
        .acc_i      (acc_q),
        .slot_i     (count_q),
        .char_i     (bus_io.char_in),
        .we_i       (accept),
        .pad_from_i (pad_from),
        .acc_o      (acc_wr),
        .pad_mask_o (pad_mask)
    );

    always_comb begin
        // With 16 chars pad_from is 16, the mask is empty and no padding applies.
        packed_word  = (acc_wr & ~pad_mask) | ({NUM_CHARS{PAD_CHAR}} & pad_mask);
        close        = (accept && (count_q == LAST_SLOT)) || (flush_eff && out_free);
        flush_pend_d = flush_eff && !close;
        count_d      = close ? slot_t'(0) : pad_from;
        acc_d        = close ? '0 : acc_wr;

        word_d       = word_q;
        word_valid_d = word_valid_q;
        if (close) begin
            word_d       = packed_word;
            word_valid_d = 1'b1;
        end else if (bus_io.word_ready) begin
            word_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            word_q       <= '0;
            count_q      <= '0;
            word_valid_q <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            word_q       <= word_d;
            count_q      <= count_d;
            word_valid_q <= word_valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign bus_io.char_ready = char_ready;
    assign bus_io.word_out   = word_q;
    assign bus_io.word_valid = word_valid_q;
    assign bus_io.char_count = count_q;

endmodule

// File: tb/tb_ascii_to_bin_packer.sv
// Self-checking bench for ascii_to_bin_packer: directed scenarios plus
// randomized throttling against a character-list reference model.
module tb_ascii_to_bin_packer;

    logic clk = 1'b0;
    logic rst_n;

    ascii_to_bin_packer_if bus ();

    ascii_to_bin_packer u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: list of characters of the open word, list of words owed.
    logic [6:0]   cur_q[$];
    logic [111:0] exp_q[$];

    task automatic model_emit();
        logic [111:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            w[k*7 +: 7] = (k < cur_q.size()) ? cur_q[k] : 7'h20;
        end
        exp_q.push_back(w);
        cur_q.delete();
    endtask

    logic         mon_en = 1'b0;
    logic         held = 1'b0;
    logic [111:0] held_word;

    // Observe handshakes at the falling edge, when all inputs and outputs are settled.
    always @(negedge clk) begin
        if (!mon_en) begin
            held = 1'b0;
            cur_q.delete();
            exp_q.delete();
        end else begin
            if (held) begin
                check("stall_valid", bus.word_valid, 1'b1);
                check("stall_word", bus.word_out, held_word);
            end
            if (bus.word_valid && bus.word_ready) begin
                if (exp_q.size() == 0) check("extra_word", bus.word_valid, 1'b0);
                else check("word", bus.word_out, exp_q.pop_front());
            end
            held      = bus.word_valid && !bus.word_ready;
            held_word = bus.word_out;
            if (bus.char_valid && bus.char_ready) begin
                cur_q.push_back(bus.char_in);
                if (cur_q.size() == 16) model_emit();
            end
            if (bus.flush && (cur_q.size() > 0)) model_emit();
        end
    end

    logic rand_en = 1'b0;
    always @(posedge clk) begin
        if (rand_en) begin
            #1 bus.word_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_char(input logic [6:0] c);
        int n;
        n = 0;
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        @(negedge clk);
        while (!bus.char_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.char_ready) check("ready_timeout", bus.char_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string        s;
        logic [111:0] w;
        logic [111:0] exp_w;
        logic [6:0]   c;

        bus.char_in    = '0;
        bus.char_valid = 1'b0;
        bus.flush      = 1'b0;
        bus.word_ready = 1'b1;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.word_valid, 1'b0);
        check("rst_word", bus.word_out, '0);
        check("rst_count", bus.char_count, 5'd0);
        check("rst_ready", bus.char_ready, 1'b1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(1);

        // Full word with an always-ready consumer.
        s = "HELLO_HAMMING_16";
        for (int i = 0; i < 16; i++) send_char(s[i][6:0]);
        w = bus.word_out;
        check("hello_valid", bus.word_valid, 1'b1);
        check("hello_slot0", w[6:0], 7'h48);
        check("hello_slot15", w[111:105], 7'h36);
        idle(2);

        // Partial word closed by flush.
        s = "ABCDE";
        for (int i = 0; i < 5; i++) send_char(s[i][6:0]);
        pulse_flush();
        exp_w = '0;
        for (int k = 0; k < 16; k++) exp_w[k*7 +: 7] = (k < 5) ? 7'(8'h41 + k) : 7'h20;
        check("flush_valid", bus.word_valid, 1'b1);
        check("flush_word", bus.word_out, exp_w);
        check("flush_count", bus.char_count, 5'd0);
        idle(2);

        // Backpressure: word 1 held while 15 chars of word 2 accumulate.
        bus.word_ready = 1'b0;
        for (int i = 0; i < 31; i++) send_char(7'(8'h61 + (i % 26)));
        check("bp_count", bus.char_count, 5'd15);
        bus.char_in    = 7'h7a;
        bus.char_valid = 1'b1;
        @(negedge clk);
        check("bp_ready_low", bus.char_ready, 1'b0);
        check("bp_word_held", bus.word_out, exp_q[0]);
        @(posedge clk);
        #1;
        bus.word_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_high", bus.char_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        check("bp_word2_valid", bus.word_valid, 1'b1);
        check("bp_count0", bus.char_count, 5'd0);
        idle(2);

        // Flush on an empty accumulator is ignored.
        pulse_flush();
        check("empty_flush_valid", bus.word_valid, 1'b0);
        idle(1);
        check("empty_flush_valid2", bus.word_valid, 1'b0);

        // Flush together with the 16th char: plain completion, no padding.
        for (int i = 0; i < 15; i++) send_char(7'(8'h30 + i));
        bus.flush = 1'b1;
        send_char(7'h51);
        bus.flush = 1'b0;
        w = bus.word_out;
        check("f16_valid", bus.word_valid, 1'b1);
        check("f16_last", w[111:105], 7'h51);
        check("f16_first", w[6:0], 7'h30);
        idle(2);

        // Async reset mid-word with a pending output.
        bus.word_ready = 1'b0;
        for (int i = 0; i < 25; i++) send_char(7'(8'h41 + (i % 26)));
        check("pre_rst_count", bus.char_count, 5'd9);
        check("pre_rst_valid", bus.word_valid, 1'b1);
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", bus.word_valid, 1'b0);
        check("arst_word", bus.word_out, '0);
        check("arst_count", bus.char_count, 5'd0);
        check("arst_ready", bus.char_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.word_ready = 1'b1;
        mon_en         = 1'b1;
        idle(1);
        for (int i = 0; i < 16; i++) send_char(7'(8'h6b + i));
        w = bus.word_out;
        check("post_rst_slot0", w[6:0], 7'h6b);
        check("post_rst_valid", bus.word_valid, 1'b1);
        idle(2);

        // Random throttling on both sides with occasional flushes.
        rand_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            idle($urandom_range(0, 2));
            c = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 29) == 0) bus.flush = 1'b1;
            send_char(c);
            bus.flush = 1'b0;
            if ($urandom_range(0, 19) == 0) pulse_flush();
        end
        rand_en = 1'b0;
        @(posedge clk);
        #2;
        bus.word_ready = 1'b1;
        pulse_flush();
        idle(6);
        check("drain_words", exp_q.size(), 0);
        check("drain_chars", cur_q.size(), 0);
        check("drain_count", bus.char_count, 5'd0);
        check("drain_valid", bus.word_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
